uart_rx_engine: RTL and testbench
=================================

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1042, clock cycles per serial bit; legal range 4..65535.
REQ-002 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n_i  input  1  reset; one clock, asynchronous, active-low.
REQ-004 rx_i  input  1  serial line; idle high; 8N1 frames, LSB first.
REQ-005 ctrl_i  input  32  current control-register contents; bit1 = new_rx flag.
REQ-006 data2_o  output  32  data-register port-2 write data, {24'b0, rx_byte}.
REQ-007 wr2_o  output  1  data-register port-2 write strobe, one cycle.
REQ-008 addr2_o  output  1  data-register port-2 entry select.
REQ-009 ctrl2_o  output  32  control-register port-2 write data.
REQ-010 ctrl_wr2_o  output  1  control-register port-2 write strobe, one cycle.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-013 overrun_o  output  1  one-cycle pulse when a byte is written while ctrl_i[1]=1.

Function
REQ-014 rx_i shall pass through a 2-flop synchronizer that resets to 1; all logic uses the synchronized value rxs.
REQ-015 The FSM shall have the states IDLE, START, DATA, STOP and WRITE, with a 16-bit bit-timer, a 3-bit bit-index, an 8-bit shift register and a 1-bit entry pointer.
REQ-016 Arming: IDLE accepts a start only after rxs=1 has been seen at least one cycle since reset or since the last frame error.
REQ-017 IDLE->START when armed and rxs=0; the timer clears to 0.
REQ-018 START samples rxs at timer = CLKS_PER_BIT/2-1 (integer division).
  - rxs=1: false start, go to IDLE with no outputs.
  - rxs=0: go to DATA with timer=0 and index=0.
REQ-019 DATA samples at timer = CLKS_PER_BIT-1.
  - Sampled bit shifts into the MSB of the shift register (LSB-first reception); timer clears.
  - Index 7 -> STOP, otherwise index+1.
REQ-020 STOP samples at timer = CLKS_PER_BIT-1.
  - rxs=1: go to WRITE.
  - rxs=0: pulse frame_err_o, disarm, go to IDLE, no writes.
REQ-021 WRITE lasts exactly one cycle, then IDLE.
  - wr2_o=1, data2_o={24'b0,byte}, addr2_o=pointer.
  - ctrl_wr2_o=1, ctrl2_o = ctrl_i | 32'h0000_0002.
  - Pointer toggles after the write.
REQ-022 In the WRITE cycle, if ctrl_i[1]=1, overrun_o shall pulse and the write shall still occur (newest byte wins).
REQ-023 Latency: if IDLE first sees rxs=0 at cycle T, wr2_o shall assert at cycle T+1+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-024 Outside WRITE: wr2_o=0, ctrl_wr2_o=0, data2_o=0, ctrl2_o=0, addr2_o=pointer.
REQ-025 Timer width: the timer shall never exceed CLKS_PER_BIT-1; there is no wrap in any state.
REQ-026 A line held low (break) shall give exactly one frame_err_o pulse and no further activity until rxs returns to 1.
REQ-027 frame_err_o and overrun_o shall never assert in the same cycle.

Reset
REQ-028 When rst_n_i=0, immediately and regardless of state:
  - state=IDLE, disarmed, timer=0, index=0, shift=0, pointer=0.
  - Synchronizer flops=1.
  - All outputs 0.
REQ-029 Reset asserted mid-frame shall abandon the frame with no write and no error pulse; after release, reception resumes only after the REQ-016 arming.

Verification (CLKS_PER_BIT=16)
REQ-030 Send 0xA5 with ctrl_i=0 -> one wr2_o pulse, data2_o=32'h0000_00A5, addr2_o=0; ctrl2_o=32'h2; no error pulses.
REQ-031 Send 0x3C then 0xFF with ctrl_i[1]=1 -> writes to addr2_o=0 then 1; overrun_o pulses on both writes; data 32'h3C then 32'hFF.
REQ-032 Low glitch of 5 cycles on idle line -> false start, busy_o returns to 0, no writes.
REQ-033 Frame 0x55 with stop bit 0 -> frame_err_o single pulse, no wr2_o; next valid 0x81 after line high -> written to addr2_o=0.
REQ-034 rst_n_i low for 3 cycles during bit 4 of a frame -> outputs 0 immediately, no write; line held low after release -> no start until rxs=1.
REQ-035 Measure start edge to wr2_o -> exactly 1+8+144 cycles after the cycle IDLE sees rxs=0 (REQ-023).

Source files
------------

// File: rtl/uart_rx_engine.sv
// 8N1 UART receiver that writes each received byte into a two-entry data register
// and flags it in the control register, reporting framing errors and overruns.
module uart_rx_engine #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_i,
    input  logic [31:0] ctrl_i,
    output logic [31:0] data2_o,
    output logic        wr2_o,
    output logic        addr2_o,
    output logic [31:0] ctrl2_o,
    output logic        ctrl_wr2_o,
    output logic        busy_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    // state | meaning
    // IDLE  | waiting for a start edge (only once armed)
    // START | timing to mid start bit to reject glitches
    // DATA  | sampling 8 data bits at bit centres, LSB first
    // STOP  | sampling the stop bit
    // WRITE | one-cycle register write of the received byte
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic        rx_meta;
    logic        rxs;
    logic [1:0]  sync_cnt;
    logic        armed;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        ptr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            sync_cnt <= 2'd0;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            if (sync_cnt != 2'd2)
                sync_cnt <= sync_cnt + 2'd1;
        end
    end

    // The synchronizer's reset value of 1 must not count as a seen-idle line,
    // so arming waits until both flops hold real samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            armed       <= 1'b0;
            timer       <= 16'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            ptr         <= 1'b0;
            data2_o     <= 32'd0;
            wr2_o       <= 1'b0;
            ctrl2_o     <= 32'd0;
            ctrl_wr2_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            data2_o     <= 32'd0;
            wr2_o       <= 1'b0;
            ctrl2_o     <= 32'd0;
            ctrl_wr2_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (rxs && sync_cnt == 2'd2)
                armed <= 1'b1;
            case (state)
                IDLE: begin
                    timer <= 16'd0;
                    if (armed && !rxs)
                        state <= START;
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            timer   <= 16'd0;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        shift <= {rxs, shift[7:1]};
                        timer <= 16'd0;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= 16'd0;
                        if (rxs) begin
                            state      <= WRITE;
                            wr2_o      <= 1'b1;
                            data2_o    <= {24'd0, shift};
                            ctrl_wr2_o <= 1'b1;
                            ctrl2_o    <= ctrl_i | 32'h0000_0002;
                            overrun_o  <= ctrl_i[1];
                        end else begin
                            state       <= IDLE;
                            frame_err_o <= 1'b1;
                            armed       <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    ptr   <= ~ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign addr2_o = ptr;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine at 16 clocks per bit: directed frames push
// expected writes/errors, a negedge monitor pops and compares them.
module tb_uart_rx_engine;

    localparam int C = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [31:0] ctrl_i = 32'd0;
    logic [31:0] data2_o;
    logic        wr2_o;
    logic        addr2_o;
    logic [31:0] ctrl2_o;
    logic        ctrl_wr2_o;
    logic        busy_o;
    logic        frame_err_o;
    logic        overrun_o;

    uart_rx_engine #(.CLKS_PER_BIT(C)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rx_i       (rx_i),
        .ctrl_i     (ctrl_i),
        .data2_o    (data2_o),
        .wr2_o      (wr2_o),
        .addr2_o    (addr2_o),
        .ctrl2_o    (ctrl2_o),
        .ctrl_wr2_o (ctrl_wr2_o),
        .busy_o     (busy_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        addr;
        logic [31:0] ctrl2;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];
    int   pending_ferr = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_wr_cyc = -1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (wr2_o) begin
            last_wr_cyc = cyc;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_data", data2_o, e.data);
                check("wr_addr", 32'(addr2_o), 32'(e.addr));
                check("wr_ctrl2", ctrl2_o, e.ctrl2);
                check("wr_ctrl_strobe", 32'(ctrl_wr2_o), 32'd1);
                check("wr_overrun", 32'(overrun_o), 32'(e.ovr));
            end
        end else begin
            check("idle_outputs", {28'd0, ctrl_wr2_o, overrun_o, (data2_o != 0), (ctrl2_o != 0)}, 32'd0);
        end
        if (frame_err_o) begin
            check("err_overrun_exclusive", 32'(overrun_o), 32'd0);
            check("frame_err_expected", 32'(pending_ferr > 0), 32'd1);
            if (pending_ferr > 0) pending_ferr--;
        end
    end

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (C) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] d, input logic a, input logic [31:0] c2, input logic ov);
        exp_t e;
        e.data = d; e.addr = a; e.ctrl2 = c2; e.ovr = ov;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle(10);
    endtask

    initial begin
        int t0;
        int busy_seen;
        logic [7:0] b;

        rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_wr2", 32'(wr2_o), 32'd0);
        check("rst_addr2", 32'(addr2_o), 32'd0);
        check("rst_data2", data2_o, 32'd0);
        check("rst_ctrl2", ctrl2_o, 32'd0);
        check("rst_flags", {29'd0, ctrl_wr2_o, frame_err_o, overrun_o}, 32'd0);
        rst_n_i = 1'b1;
        idle(10);

        // 0xA5 with ctrl 0, also measuring start-edge-to-write latency
        ctrl_i = 32'd0;
        expect_write(32'h0000_00A5, 1'b0, 32'h0000_0002, 1'b0);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("latency_cycle", 32'(last_wr_cyc), 32'(t0 + 2 + 153));

        // back-to-back with new_rx already set: overruns, pointer alternates
        do_reset();
        ctrl_i = 32'h8000_0012;
        expect_write(32'h0000_003C, 1'b0, 32'h8000_0012, 1'b1);
        expect_write(32'h0000_00FF, 1'b1, 32'h8000_0012, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        send_frame(8'hFF, 1'b1);
        idle(20);
        ctrl_i = 32'd0;

        // 5-cycle low glitch -> false start
        rx_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        check("glitch_busy", 32'(busy_o), 32'd1);
        idle(20);
        check("glitch_busy_clear", 32'(busy_o), 32'd0);

        // bad stop bit, then held low as a break: one error, no restart
        pending_ferr++;
        send_frame(8'h55, 1'b0);
        busy_seen = 0;
        repeat (60) begin
            @(posedge clk_i);
            #1;
            if (busy_o) busy_seen++;
        end
        check("break_busy_cycles", 32'(busy_seen), 32'd0);
        idle(20);
        ctrl_i = 32'h0000_0100;
        expect_write(32'h0000_0081, 1'b0, 32'h0000_0102, 1'b0);
        send_frame(8'h81, 1'b1);
        idle(20);
        ctrl_i = 32'd0;

        // reset during bit 4, line then held low
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_i = b[4];
        repeat (5) @(posedge clk_i);
        #3;
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        rx_i = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_addr2", 32'(addr2_o), 32'd0);
        check("midrst_outputs", {28'd0, wr2_o, ctrl_wr2_o, frame_err_o, overrun_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (busy_o) busy_seen++;
        end
        check("low_after_reset_busy", 32'(busy_seen), 32'd0);
        idle(20);
        expect_write(32'h0000_0042, 1'b0, 32'h0000_0002, 1'b0);
        send_frame(8'h42, 1'b1);
        idle(30);

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("pending_frame_errors", 32'(pending_ferr), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
